// File: rtl/sprite_loader.sv
// SPI command sequencer: parses opcode/index/pixel-byte frames and drives the
// sprite storage write port, tracking which sprite buffers hold a complete load.
module sprite_loader #(
  parameter int         SPRITE_NUM       = 8,
  parameter int         SPRITE_ADDR_SIZE = 11,
  parameter int         SPRITE_BYTES     = 2048,
  parameter logic [7:0] OP_LOAD          = 8'h01
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cs_active,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic [$clog2(SPRITE_NUM)-1:0] w_select,
  output logic                          w_en,
  output logic [SPRITE_ADDR_SIZE:0]     w_addr,
  output logic [7:0]                    w_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [SPRITE_NUM-1:0]         loaded
);

  localparam int IDX_W  = $clog2(SPRITE_NUM);
  localparam int CNT_W  = $clog2(SPRITE_BYTES);
  localparam int ADDR_W = SPRITE_ADDR_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(SPRITE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, INDEX, DATA, DRAIN} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] byte_count;
  logic             take_index, take_byte, last_byte, err_set, done_set;
  logic             idx_ok;

  assign idx_ok    = 32'(rx_data) < 32'(SPRITE_NUM);
  assign last_byte = byte_count == LAST_BYTE;
  assign busy      = state != IDLE;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // cs_active low overrides rx_valid in every state, so a byte arriving with
  // the frame edge is never consumed.
  always_comb begin
    state_next = state;
    take_index = 1'b0;
    take_byte  = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && cs_active) begin
          if (rx_data == OP_LOAD) state_next = INDEX;
          else begin
            err_set    = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      INDEX: begin
        if (!cs_active) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (rx_valid) begin
          if (idx_ok) begin
            take_index = 1'b1;
            state_next = DATA;
          end else begin
            err_set    = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DATA: begin
        if (!cs_active) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (rx_valid) begin
          take_byte = 1'b1;
          if (last_byte) begin
            done_set   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!cs_active) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      w_en       <= 1'b0;
      w_select   <= '0;
      w_addr     <= '0;
      w_data     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      loaded     <= '0;
      byte_count <= '0;
    end else begin
      w_en <= take_byte;
      done <= done_set;
      err  <= err_set;
      if (take_index) begin
        w_select                   <= rx_data[IDX_W-1:0];
        byte_count                 <= '0;
        loaded[rx_data[IDX_W-1:0]] <= 1'b0;
      end
      if (take_byte) begin
        w_data     <= rx_data;
        w_addr     <= ADDR_W'({byte_count, 1'b0});
        byte_count <= byte_count + 1'b1;
        if (last_byte) loaded[w_select] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Bench for sprite_loader: scoreboard-checked write stream plus a table of
// single-cycle protocol steps and hand-written abort/reset sequences.
module tb_sprite_loader;

  localparam int BYTES = 2048;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] w_select;
  logic       w_en;
  logic [11:0] w_addr;
  logic [7:0] w_data;
  logic       busy, done, err;
  logic [7:0] loaded;

  sprite_loader #(
    .SPRITE_NUM(8),
    .SPRITE_ADDR_SIZE(11),
    .SPRITE_BYTES(2048),
    .OP_LOAD(8'h01)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cs_active(cs_active),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .w_select(w_select),
    .w_en(w_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .busy(busy),
    .done(done),
    .err(err),
    .loaded(loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_t;

  typedef struct {
    logic       cs;
    logic       valid;
    logic [7:0] data;
    logic       exp_busy;
    logic       exp_err;
  } step_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_writes = 0;
  int         run = 0;
  int         max_run = 0;
  logic [2:0] cur_sel = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Write-port monitor: every w_en must match the oldest expected write.
  always @(posedge clock) begin
    wr_t e;
    #1;
    if (reset_n) begin
      if (w_en) begin
        run++;
        n_writes++;
        if (exp_q.size() == 0) flag_fail("unexpected_write");
        else begin
          e = exp_q.pop_front();
          check("write", 32'({w_select, w_addr, w_data, done}),
                32'({e.sel, e.addr, e.data, e.last}));
        end
      end else begin
        run = 0;
        if (done) flag_fail("done_without_write");
      end
      if (run > max_run) max_run = run;
      if (done && err) flag_fail("done_err_overlap");
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic cs, input logic v, input logic [7:0] d);
    @(negedge clock);
    cs_active = cs;
    rx_valid  = v;
    rx_data   = d;
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic start_frame(input logic [7:0] idx);
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b1, idx);
    cur_sel = idx[2:0];
  endtask

  task automatic data_byte(input int k, input logic [7:0] d, input logic last);
    wr_t e;
    drive(1'b1, 1'b1, d);
    e.sel  = cur_sel;
    e.addr = 12'(2 * k);
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic full_load(input logic [7:0] idx, input int salt);
    start_frame(idx);
    for (int k = 0; k < BYTES; k++)
      data_byte(k, 8'((k * salt + int'(idx) * (salt - 1)) & 8'hFF), k == BYTES - 1);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    settle();
  endtask

  step_t steps[16];
  int    w0;

  initial begin
    steps[0]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1};  // bad opcode -> DRAIN
    steps[1]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    steps[2]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    steps[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    steps[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};  // frame end -> IDLE
    steps[5]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    steps[6]  = '{1'b1, 1'b1, 8'h09, 1'b1, 1'b1};  // index out of range
    steps[7]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    steps[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    steps[9]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0};  // rx_valid without cs ignored
    steps[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    steps[11] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    steps[12] = '{1'b1, 1'b1, 8'h08, 1'b1, 1'b1};  // index == SPRITE_NUM
    steps[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    steps[14] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    steps[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1};  // cs drop in INDEX

    // Reset
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    settle();
    check("reset_outputs", 32'({w_en, w_select, w_addr, w_data, busy, done, err}), 32'h0);
    check("reset_loaded", 32'(loaded), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Full back-to-back load of sprite 3 with data k & 0xFF
    max_run = 0;
    w0 = n_writes;
    full_load(8'h03, 1);
    check("load3_loaded", 32'(loaded), 32'h08);
    check("load3_writes", 32'(n_writes - w0), 32'(BYTES));
    check("load3_run", 32'(max_run), 32'(BYTES));
    check("load3_busy", 32'(busy), 32'h0);
    check("load3_queue", 32'(exp_q.size()), 32'h0);

    // Protocol steps with no writes expected
    for (int i = 0; i < 16; i++) begin
      drive(steps[i].cs, steps[i].valid, steps[i].data);
      settle();
      check($sformatf("step%0d_busy", i), 32'(busy), 32'(steps[i].exp_busy));
      check($sformatf("step%0d_err", i), 32'(err), 32'(steps[i].exp_err));
    end
    check("steps_loaded", 32'(loaded), 32'h08);

    // Partial load of sprite 2 with idle gaps, aborted by frame end
    w0 = n_writes;
    start_frame(8'h02);
    for (int k = 0; k < 100; k++) begin
      data_byte(k, 8'(k ^ 8'h5A), 1'b0);
      drive(1'b1, 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 8'h00);
    settle();
    check("abort2_err", 32'(err), 32'h1);
    check("abort2_busy", 32'(busy), 32'h0);
    check("abort2_writes", 32'(n_writes - w0), 32'd100);
    check("abort2_loaded", 32'(loaded), 32'h08);
    settle();
    check("abort2_err_pulse", 32'(err), 32'h0);

    // Full reload of sprite 2
    full_load(8'h02, 7);
    check("reload2_loaded", 32'(loaded), 32'h0C);
    check("reload2_queue", 32'(exp_q.size()), 32'h0);

    // Accepting index 3 again clears loaded[3] even if aborted
    start_frame(8'h03);
    drive(1'b0, 1'b0, 8'h00);
    settle();
    check("reindex3_err", 32'(err), 32'h1);
    check("reindex3_loaded", 32'(loaded), 32'h04);

    // Reset during DATA
    start_frame(8'h05);
    for (int k = 0; k < 10; k++) data_byte(k, 8'(8'hC0 + k), 1'b0);
    @(negedge clock);
    reset_n  = 1'b0;
    rx_data  = 8'hAA;
    settle();
    check("midreset_outputs", 32'({w_en, w_select, w_addr, w_data, busy, done, err}), 32'h0);
    check("midreset_loaded", 32'(loaded), 32'h0);
    check("midreset_queue", 32'(exp_q.size()), 32'h0);
    @(negedge clock);
    reset_n   = 1'b1;
    cs_active = 1'b0;
    rx_valid  = 1'b0;
    settle();
    check("postreset_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
